// File: rtl/gba_audio_sequencer.sv
// gba_audio_sequencer: 512 Hz PSG frame sequencer plus mixer sample-rate divider.
// Define GBA_AUDIO_SEQ_FAST_SIM_EN to shorten the frame divider by 256x for simulation.
module gba_audio_sequencer #(
    parameter int CLK_DIV_512     = 32768,
    parameter int SAMPLE_BASE_DIV = 512
) (
    input  logic       gba_clk,
    input  logic       reset,
    input  logic       master_en,
    input  logic       seq_restart,
    input  logic [1:0] bias_res,
    output logic       step_strobe,
    output logic [2:0] step,
    output logic       length_tick,
    output logic       sweep_tick,
    output logic       env_tick,
    output logic       sample_tick,
    output logic [1:0] res_active
);
    localparam int DW = $clog2(CLK_DIV_512);
    localparam int SW = $clog2(SAMPLE_BASE_DIV);
`ifdef GBA_AUDIO_SEQ_FAST_SIM_EN
    localparam int FRAME_DIV = CLK_DIV_512 / 256;
`else
    localparam int FRAME_DIV = CLK_DIV_512;
`endif

    logic [DW-1:0] div_cnt;
    logic [SW-1:0] sample_cnt;
    logic [SW-1:0] sample_last;
    logic [2:0]    next_step;
    logic          frame_tc;
    logic          sample_tc;

    // The sample period is a power-of-two base shifted down, so its last count shifts too.
    always_comb begin
        next_step   = step + 3'd1;
        frame_tc    = div_cnt == DW'(FRAME_DIV - 1);
        sample_last = SW'(SAMPLE_BASE_DIV - 1) >> res_active;
        sample_tc   = sample_cnt == sample_last;
    end

    // Master disable and restart park the sequencer so the next fired step is 0.
    always_ff @(posedge gba_clk) begin
        if (reset || !master_en || seq_restart) begin
            div_cnt     <= '0;
            step        <= 3'd7;
            step_strobe <= 1'b0;
            length_tick <= 1'b0;
            sweep_tick  <= 1'b0;
            env_tick    <= 1'b0;
        end else begin
            div_cnt     <= frame_tc ? '0 : div_cnt + 1'b1;
            step        <= frame_tc ? next_step : step;
            step_strobe <= frame_tc;
            length_tick <= frame_tc & ~next_step[0];
            sweep_tick  <= frame_tc & (next_step == 3'd2 || next_step == 3'd6);
            env_tick    <= frame_tc & (next_step == 3'd7);
        end
    end

    // Resolution is only adopted at a period boundary, so no period is ever cut or stretched.
    always_ff @(posedge gba_clk) begin
        if (reset) begin
            sample_cnt  <= '0;
            sample_tick <= 1'b0;
            res_active  <= 2'd0;
        end else begin
            sample_cnt  <= sample_tc ? '0 : sample_cnt + 1'b1;
            sample_tick <= sample_tc;
            res_active  <= sample_tc ? bias_res : res_active;
        end
    end
endmodule

// File: tb/tb_gba_audio_sequencer.sv
// tb_gba_audio_sequencer: directed checks of step sequencing, gating, restart, sample rates and reset.
// The frame divider is overridden to 1024 so the whole run stays short.
module tb_gba_audio_sequencer;
    localparam int DIV = 1024;
`ifdef GBA_AUDIO_SEQ_FAST_SIM_EN
    localparam int P = DIV / 256;
`else
    localparam int P = DIV;
`endif
    localparam int MID = (P > 1000) ? 1000 : 1;

    logic       gba_clk = 1'b0;
    logic       reset = 1'b1;
    logic       master_en = 1'b0;
    logic       seq_restart = 1'b0;
    logic [1:0] bias_res = 2'd0;
    logic       step_strobe, length_tick, sweep_tick, env_tick, sample_tick;
    logic [2:0] step;
    logic [1:0] res_active;

    int tests = 0;
    int fails = 0;

    gba_audio_sequencer #(.CLK_DIV_512(DIV), .SAMPLE_BASE_DIV(512)) dut (
        .gba_clk(gba_clk), .reset(reset), .master_en(master_en), .seq_restart(seq_restart),
        .bias_res(bias_res), .step_strobe(step_strobe), .step(step), .length_tick(length_tick),
        .sweep_tick(sweep_tick), .env_tick(env_tick), .sample_tick(sample_tick), .res_active(res_active)
    );

    always #5 gba_clk = ~gba_clk;

    task automatic wait_strobe(input int limit, output int n, output int stray);
        n = 0;
        stray = 0;
        do begin
            @(negedge gba_clk);
            n++;
            if (!step_strobe && (length_tick || sweep_tick || env_tick)) stray++;
        end while (!step_strobe && n < limit);
    endtask

    task automatic wait_sample(input int limit, output int n);
        n = 0;
        do begin
            @(negedge gba_clk);
            n++;
        end while (!sample_tick && n < limit);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        master_en = 1'b1;
        bias_res = 2'd3;
        repeat (3) @(negedge gba_clk);
        tests++;
        if ({step_strobe, length_tick, sweep_tick, env_tick, sample_tick} !== 5'b0) begin
            fails++;
            $display("FAIL reset_ticks: got %b expected 00000",
                     {step_strobe, length_tick, sweep_tick, env_tick, sample_tick});
        end
        tests++;
        if (step !== 3'd7) begin fails++; $display("FAIL reset_step: got %0d expected 7", step); end
        tests++;
        if (res_active !== 2'd0) begin fails++; $display("FAIL reset_res: got %0d expected 0", res_active); end
    endtask

    task automatic test_step_sequence;
        logic [2:0] exp_ticks [8] = '{3'b100, 3'b000, 3'b110, 3'b000, 3'b100, 3'b000, 3'b110, 3'b001};
        int n, stray, exp_n;
        bias_res = 2'd0;
        master_en = 1'b1;
        reset = 1'b0;
        for (int s = 0; s < 8; s++) begin
            wait_strobe(2 * P + 2, n, stray);
            exp_n = (s == 0) ? P : P - 1;
            tests++;
            if (n !== exp_n) begin fails++; $display("FAIL seq_spacing[%0d]: got %0d expected %0d", s, n, exp_n); end
            tests++;
            if (stray !== 0) begin fails++; $display("FAIL seq_stray[%0d]: got %0d expected 0", s, stray); end
            tests++;
            if (step !== 3'(s)) begin fails++; $display("FAIL seq_step[%0d]: got %0d expected %0d", s, step, s); end
            tests++;
            if ({length_tick, sweep_tick, env_tick} !== exp_ticks[s]) begin
                fails++;
                $display("FAIL seq_ticks[%0d]: got %b expected %b", s, {length_tick, sweep_tick, env_tick}, exp_ticks[s]);
            end
`ifndef GBA_AUDIO_SEQ_FAST_SIM_EN
            if (s == 0) begin
                tests++;
                if (sample_tick !== 1'b1) begin fails++; $display("FAIL seq_coincide: got %b expected 1", sample_tick); end
            end
`endif
            @(negedge gba_clk);
            tests++;
            if ({step_strobe, length_tick, sweep_tick, env_tick} !== 4'b0) begin
                fails++;
                $display("FAIL seq_width[%0d]: got %b expected 0000", s, {step_strobe, length_tick, sweep_tick, env_tick});
            end
        end
    endtask

    task automatic test_master_gate;
        int n, stray, cnt;
        master_en = 1'b0;
        cnt = 0;
        repeat (3000) begin
            @(negedge gba_clk);
            if (step_strobe || length_tick || sweep_tick || env_tick) cnt++;
        end
        tests++;
        if (cnt !== 0) begin fails++; $display("FAIL gate_quiet: got %0d strobes expected 0", cnt); end
        tests++;
        if (step !== 3'd7) begin fails++; $display("FAIL gate_step: got %0d expected 7", step); end
        master_en = 1'b1;
        wait_strobe(2 * P + 2, n, stray);
        tests++;
        if (n !== P) begin fails++; $display("FAIL gate_first: got %0d expected %0d", n, P); end
        tests++;
        if (step !== 3'd0) begin fails++; $display("FAIL gate_step0: got %0d expected 0", step); end
    endtask

    task automatic test_restart_collision;
        int n, stray;
        repeat (P - 1) @(negedge gba_clk);
        seq_restart = 1'b1;
        @(negedge gba_clk);
        seq_restart = 1'b0;
        tests++;
        if (step_strobe !== 1'b0) begin fails++; $display("FAIL restart_strobe: got %b expected 0", step_strobe); end
        tests++;
        if (step !== 3'd7) begin fails++; $display("FAIL restart_step: got %0d expected 7", step); end
        wait_strobe(2 * P + 2, n, stray);
        tests++;
        if (n !== P) begin fails++; $display("FAIL restart_next: got %0d expected %0d", n, P); end
        tests++;
        if (step !== 3'd0) begin fails++; $display("FAIL restart_step0: got %0d expected 0", step); end
    endtask

    task automatic test_sample_rates;
        int n;
        master_en = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge gba_clk);
        bias_res = 2'd0;
        reset = 1'b0;
        wait_sample(1200, n);
        tests++;
        if (n !== 512) begin fails++; $display("FAIL sample_first: got %0d expected 512", n); end
        @(negedge gba_clk);
        tests++;
        if (sample_tick !== 1'b0) begin fails++; $display("FAIL sample_width: got %b expected 0", sample_tick); end
        bias_res = 2'd3;
        wait_sample(1200, n);
        tests++;
        if (n !== 511) begin fails++; $display("FAIL sample_hold512: got %0d expected 511", n); end
        tests++;
        if (res_active !== 2'd3) begin fails++; $display("FAIL sample_res3: got %0d expected 3", res_active); end
        wait_sample(1200, n);
        tests++;
        if (n !== 64) begin fails++; $display("FAIL sample_64: got %0d expected 64", n); end
        repeat (10) @(negedge gba_clk);
        bias_res = 2'd1;
        tests++;
        if (res_active !== 2'd3) begin fails++; $display("FAIL sample_midres: got %0d expected 3", res_active); end
        wait_sample(1200, n);
        tests++;
        if (n !== 54) begin fails++; $display("FAIL sample_hold64: got %0d expected 54", n); end
        tests++;
        if (res_active !== 2'd1) begin fails++; $display("FAIL sample_res1: got %0d expected 1", res_active); end
        wait_sample(1200, n);
        tests++;
        if (n !== 256) begin fails++; $display("FAIL sample_256: got %0d expected 256", n); end
    endtask

    task automatic test_mid_run_reset;
        int n, stray;
        reset = 1'b1;
        repeat (2) @(negedge gba_clk);
        bias_res = 2'd2;
        master_en = 1'b1;
        reset = 1'b0;
        repeat (6) wait_strobe(2 * P + 2, n, stray);
        tests++;
        if (step !== 3'd5) begin fails++; $display("FAIL midrst_pre: got %0d expected 5", step); end
        repeat (MID) @(negedge gba_clk);
        reset = 1'b1;
        @(negedge gba_clk);
        tests++;
        if ({step_strobe, length_tick, sweep_tick, env_tick, sample_tick, res_active} !== 7'b0) begin
            fails++;
            $display("FAIL midrst_out: got %b expected 0000000",
                     {step_strobe, length_tick, sweep_tick, env_tick, sample_tick, res_active});
        end
        tests++;
        if (step !== 3'd7) begin fails++; $display("FAIL midrst_step: got %0d expected 7", step); end
        reset = 1'b0;
        wait_strobe(2 * P + 2, n, stray);
        tests++;
        if (n !== P) begin fails++; $display("FAIL midrst_first: got %0d expected %0d", n, P); end
        tests++;
        if (step !== 3'd0) begin fails++; $display("FAIL midrst_step0: got %0d expected 0", step); end
    endtask

    initial begin
        test_reset();
        test_step_sequence();
        test_master_gate();
        test_restart_collision();
        test_sample_rates();
        test_mid_run_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
